spi_shift_ctrl: RTL and testbench
=================================

Name: spi_shift_ctrl

Overview:
Character-level SPI master shift engine that sits directly around spi_clk_gen.
- Accepts a parallel TX word via valid/ready.
- Drives the clock generator's GO and LAST_CLK inputs.
- Consumes its POS/NEG edge flags to shift MOSI and sample MISO.
- Returns the received word with a one-cycle valid pulse.
- Owns the chip select for the duration of each character.

Parameters:
DW, 8, character width in bits (2..32)
CW, 6, edge-counter width; must satisfy 2^CW > 2*DW

Ports:
I_SYS_CLK  in  1  system clock; single clock domain
I_RST_N  in  1  asynchronous active-low reset
I_EN  in  1  module enable; low = synchronous abort to IDLE
I_CPOL  in  1  clock polarity, same value as fed to spi_clk_gen
I_CPHA  in  1  clock phase
I_LSB_FIRST  in  1  1 = shift LSB first, 0 = MSB first
I_TX_DATA  in  DW  word to transmit
I_TX_VALID  in  1  TX word valid
O_TX_READY  out  1  engine can accept a word
O_RX_DATA  out  DW  last received word
O_RX_VALID  out  1  one-cycle pulse; O_RX_DATA updated
I_POS_EDGE  in  1  spi_clk_gen O_POS_EGDE
I_NEG_EDGE  in  1  spi_clk_gen O_NEG_EGDE
O_GO  out  1  start pulse to spi_clk_gen I_GO
O_LAST_CLK  out  1  to spi_clk_gen I_LAST_CLK
O_MOSI  out  1  serial data out
I_MISO  in  1  serial data in (already synchronised upstream)
O_CS_N  out  1  chip select, active low
O_BUSY  out  1  character in progress

Behaviour:
- Reset values: O_TX_READY=0, O_RX_DATA=0, O_RX_VALID=0, O_GO=0, O_LAST_CLK=0, O_MOSI=0, O_CS_N=1, O_BUSY=0, state=IDLE, shift regs=0, edge count=0.
- Edge flags:
  - LEAD = I_CPOL ? I_NEG_EDGE : I_POS_EDGE.
  - TRAIL = I_CPOL ? I_POS_EDGE : I_NEG_EDGE.
  - LEAD and TRAIL high in the same cycle is unsupported; I_DIVIDER >= 1 is required system-wide. The bench asserts this never happens.
- All outputs are registered.
- State machine: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - O_TX_READY = I_EN (registered, so it is valid the cycle after I_EN rises).
  - On I_TX_VALID && O_TX_READY:
    - latch I_TX_DATA into the TX shift register;
    - edge count <= 2*DW;
    - O_CS_N <= 0, O_BUSY <= 1, O_TX_READY <= 0;
    - O_GO <= 1 for exactly one cycle;
    - go to XFER.
  - CPHA=0: O_MOSI <= first bit in that same cycle, so it is valid before the first edge.
- XFER: every LEAD or TRAIL flag decrements the edge count.
  - CPHA=0:
    - LEAD samples I_MISO into the RX shift register.
    - TRAIL drives the next bit on O_MOSI; no drive on the final TRAIL.
  - CPHA=1:
    - LEAD drives the next bit on O_MOSI; the first LEAD drives bit 0 of the order.
    - TRAIL samples I_MISO.
  - Bit order: I_LSB_FIRST=1 shifts right, sends bit[0] first, and fills RX from the MSB end. I_LSB_FIRST=0 mirrors this.
  - O_LAST_CLK <= 1 when the edge count goes 2 -> 1, and is held until IDLE.
  - When the edge count goes 1 -> 0, go to DONE.
- DONE (1 cycle):
  - O_RX_DATA <= assembled RX word; O_RX_VALID pulses 1 cycle.
  - O_CS_N <= 1, O_BUSY <= 0, O_LAST_CLK <= 0, O_MOSI held.
  - Go to IDLE. O_TX_READY reasserts the following cycle, so the minimum gap between characters is 2 system clocks.
- I_TX_VALID while busy: ignored, since ready is low. The TX word must be held by the source until accepted.
- I_EN low in any state: next cycle the block is in IDLE with O_CS_N=1, O_BUSY=0, O_LAST_CLK=0, O_GO=0, and no O_RX_VALID. O_RX_DATA keeps its old value.
- Asynchronous reset mid-transfer: all outputs go to their reset values immediately.
- Edge count width: CW bits. The load value 2*DW is computed at elaboration time, with no run-time overflow.

Decomposition:
- spi_pkg holds:
  - state encoding constants (IDLE/XFER/DONE);
  - a CPOL-dependent LEAD/TRAIL select helper;
  - mode constants SPI_MODE0..3 for benches.
- No sub-module is required. The shift register and edge counter live in one always-block each.
- Optional sub-module spi_bit_shifter (DW-wide bidirectional shift/sample register with LSB/MSB select) is reusable by the future slave block.

Test Plan:
- Mode 0 with DW=8, MOSI looped to MISO, send 0xA5 MSB first:
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - 16 edge flags consumed, O_GO exactly 1 pulse;
  - O_RX_DATA=0xA5 with one O_RX_VALID pulse;
  - O_CS_N low only between GO and DONE.
- Mode 3 (CPOL=1, CPHA=1), LSB first, TX 0x3C, MISO driven 0x81 LSB first:
  - MOSI bits 0,0,1,1,1,1,0,0;
  - RX=0x81;
  - O_LAST_CLK rises after the 15th edge flag.
- Back-to-back: TX_VALID held high with 0x11 then 0x22:
  - two RX_VALID pulses;
  - O_TX_READY low throughout each XFER;
  - CS_N high for at least 1 cycle between characters.
- Abort: I_EN dropped after the 5th edge flag:
  - next cycle O_CS_N=1, O_BUSY=0, state IDLE;
  - no RX_VALID;
  - O_RX_DATA unchanged from the previous character.
- Reset mid-transfer: I_RST_N pulsed low asynchronously during XFER:
  - all outputs at reset values that same cycle;
  - after release with I_EN=1, O_TX_READY=1 and a new 0xFF transfer completes correctly.
- Busy guard: I_TX_VALID pulsed with 0x77 during XFER and dropped before DONE:
  - word not accepted;
  - no second O_GO;
  - exactly one RX_VALID for the original word.

Source files
------------

// File: rtl/spi_shift_ctrl_pkg.sv
// spi_shift_ctrl_pkg: shared types and helpers for the SPI master shift engine.
//   - spi_state_e     : engine state encoding (IDLE / XFER / DONE)
//   - SPI_MODE0..3    : {cpol, cpha} mode constants
//   - spi_lead_sel    : picks the leading SCLK edge flag for a given CPOL
//   - spi_trail_sel   : picks the trailing SCLK edge flag for a given CPOL
package spi_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } spi_state_e;

  // Mode encoding is {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Leading edge leaves the idle level: rising for CPOL=0, falling for CPOL=1
  function automatic logic spi_lead_sel(input logic cpol, input logic pos, input logic neg);
    return cpol ? neg : pos;
  endfunction

  // Trailing edge returns to the idle level
  function automatic logic spi_trail_sel(input logic cpol, input logic pos, input logic neg);
    return cpol ? pos : neg;
  endfunction

endpackage

// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: character-level SPI master shift engine wrapped around spi_clk_gen.
// Ports:
//   I_SYS_CLK, I_RST_N          : clock, async active-low reset
//   I_EN                        : enable, low aborts to IDLE synchronously
//   I_CPOL, I_CPHA, I_LSB_FIRST : SPI mode and bit order
//   I_TX_DATA/VALID, O_TX_READY : parallel TX word handshake
//   O_RX_DATA, O_RX_VALID       : received word and one-cycle valid pulse
//   I_POS_EDGE, I_NEG_EDGE      : SCLK edge flags from spi_clk_gen
//   O_GO, O_LAST_CLK            : control to spi_clk_gen
//   O_MOSI, I_MISO              : serial data
//   O_CS_N, O_BUSY              : chip select and character-in-progress
module spi_shift_ctrl
  import spi_shift_ctrl_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 6
) (
  input  logic          I_SYS_CLK,
  input  logic          I_RST_N,
  input  logic          I_EN,
  input  logic          I_CPOL,
  input  logic          I_CPHA,
  input  logic          I_LSB_FIRST,
  input  logic [DW-1:0] I_TX_DATA,
  input  logic          I_TX_VALID,
  output logic          O_TX_READY,
  output logic [DW-1:0] O_RX_DATA,
  output logic          O_RX_VALID,
  input  logic          I_POS_EDGE,
  input  logic          I_NEG_EDGE,
  output logic          O_GO,
  output logic          O_LAST_CLK,
  output logic          O_MOSI,
  input  logic          I_MISO,
  output logic          O_CS_N,
  output logic          O_BUSY
);

  // Two edges per bit; fixed at elaboration so no run-time overflow
  localparam logic [CW-1:0] CNT_LOAD = CW'(2 * DW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  spi_state_e    state_q, state_d;
  logic [DW-1:0] tx_sr_q, tx_sr_d;
  logic [DW-1:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_ready_q, tx_ready_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          go_q, go_d;
  logic          last_clk_q, last_clk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;

  logic lead_c, trail_c, accept_c, in_xfer_c, edge_c, drive_c, sample_c;

  // Bit that goes out next for the selected order
  function automatic logic head_bit(input logic [DW-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DW-1];
  endfunction

  // Drop the bit just sent
  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DW-1:1]} : {w[DW-2:0], 1'b0};
  endfunction

  assign lead_c    = spi_lead_sel(I_CPOL, I_POS_EDGE, I_NEG_EDGE);
  assign trail_c   = spi_trail_sel(I_CPOL, I_POS_EDGE, I_NEG_EDGE);
  assign accept_c  = (state_q == ST_IDLE) && I_EN && I_TX_VALID && tx_ready_q;
  assign in_xfer_c = (state_q == ST_XFER) && I_EN;
  assign edge_c    = in_xfer_c && (lead_c || trail_c);
  // CPHA=0 has its first bit out before the first edge, so the final trail drives nothing
  assign drive_c   = in_xfer_c && (I_CPHA ? lead_c : (trail_c && (cnt_q != CNT_ONE)));
  assign sample_c  = in_xfer_c && (I_CPHA ? trail_c : lead_c);

  // Control FSM and handshake outputs
  always_comb begin
    state_d    = state_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    go_d       = 1'b0;
    last_clk_d = last_clk_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_ready_d = I_EN;
        if (accept_c) begin
          state_d    = ST_XFER;
          tx_ready_d = 1'b0;
          go_d       = 1'b1;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_XFER: begin
        tx_ready_d = 1'b0;
        if (edge_c) begin
          if (cnt_q == CNT_TWO) last_clk_d = 1'b1;
          if (cnt_q == CNT_ONE) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        tx_ready_d = 1'b0;
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
        cs_n_d     = 1'b1;
        busy_d     = 1'b0;
        last_clk_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything; the last received word is kept
    if (!I_EN) begin
      state_d    = ST_IDLE;
      tx_ready_d = 1'b0;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      go_d       = 1'b0;
      last_clk_d = 1'b0;
      cs_n_d     = 1'b1;
      busy_d     = 1'b0;
    end
  end

  // Edge counter
  always_comb begin
    cnt_d = cnt_q;
    if (!I_EN)         cnt_d = '0;
    else if (accept_c) cnt_d = CNT_LOAD;
    else if (edge_c)   cnt_d = cnt_q - CNT_ONE;
  end

  // TX/RX shift registers and MOSI
  always_comb begin
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    mosi_d  = mosi_q;
    if (accept_c) begin
      rx_sr_d = '0;
      if (I_CPHA) begin
        tx_sr_d = I_TX_DATA;
      end else begin
        mosi_d  = head_bit(I_TX_DATA, I_LSB_FIRST);
        tx_sr_d = shift_out(I_TX_DATA, I_LSB_FIRST);
      end
    end
    if (drive_c) begin
      mosi_d  = head_bit(tx_sr_q, I_LSB_FIRST);
      tx_sr_d = shift_out(tx_sr_q, I_LSB_FIRST);
    end
    if (sample_c) begin
      rx_sr_d = I_LSB_FIRST ? {I_MISO, rx_sr_q[DW-1:1]} : {rx_sr_q[DW-2:0], I_MISO};
    end
  end

  // State and output registers
  always_ff @(posedge I_SYS_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      go_q       <= 1'b0;
      last_clk_q <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      cnt_q      <= cnt_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      go_q       <= go_d;
      last_clk_q <= last_clk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
    end
  end

  assign O_TX_READY = tx_ready_q;
  assign O_RX_DATA  = rx_data_q;
  assign O_RX_VALID = rx_valid_q;
  assign O_GO       = go_q;
  assign O_LAST_CLK = last_clk_q;
  assign O_MOSI     = mosi_q;
  assign O_CS_N     = cs_n_q;
  assign O_BUSY     = busy_q;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl: directed bench for spi_shift_ctrl with a behavioural
// spi_clk_gen stand-in (one SCLK edge flag every DIV clocks) and an SPI slave model.
module tb_spi_shift_ctrl;
  import spi_shift_ctrl_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 6;
  localparam int          DIV = 2;

  logic          clk = 1'b0;
  logic          I_RST_N, I_EN, I_CPOL, I_CPHA, I_LSB_FIRST;
  logic [DW-1:0] I_TX_DATA;
  logic          I_TX_VALID, I_POS_EDGE, I_NEG_EDGE;
  logic          O_TX_READY, O_RX_VALID, O_GO, O_LAST_CLK, O_MOSI, O_CS_N, O_BUSY;
  logic [DW-1:0] O_RX_DATA;
  logic          loop_en, miso_drv;
  wire           miso_w = loop_en ? O_MOSI : miso_drv;

  always #5 clk = ~clk;

  spi_shift_ctrl #(.DW(DW), .CW(CW)) dut (
    .I_SYS_CLK(clk), .I_RST_N(I_RST_N), .I_EN(I_EN),
    .I_CPOL(I_CPOL), .I_CPHA(I_CPHA), .I_LSB_FIRST(I_LSB_FIRST),
    .I_TX_DATA(I_TX_DATA), .I_TX_VALID(I_TX_VALID), .O_TX_READY(O_TX_READY),
    .O_RX_DATA(O_RX_DATA), .O_RX_VALID(O_RX_VALID),
    .I_POS_EDGE(I_POS_EDGE), .I_NEG_EDGE(I_NEG_EDGE),
    .O_GO(O_GO), .O_LAST_CLK(O_LAST_CLK), .O_MOSI(O_MOSI), .I_MISO(miso_w),
    .O_CS_N(O_CS_N), .O_BUSY(O_BUSY)
  );

  typedef struct {
    logic [1:0] mode;
    logic       lsb;
    logic       loop;
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  int n_cmp = 0;
  int n_err = 0;

  // Clock-gen and slave model state
  bit         run;
  int         div_cnt;
  logic       sclk;
  int         edge_n, mosi_n, go_cnt, rxv_cnt, cs_err, rdy_err, last_rise, gap;
  bit         last_seen;
  logic [7:0] mosi_word, cur_slv, rx_last;
  logic [7:0] rxw[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    edge_n = 0; mosi_n = 0; go_cnt = 0; rxv_cnt = 0; cs_err = 0; rdy_err = 0;
    last_rise = -1; last_seen = 0; mosi_word = '0; gap = 0;
  endtask

  // One system clock: sample outputs #1 after the edge, then drive next inputs
  task automatic step();
    logic pos, neg, is_lead;
    int   b;
    @(posedge clk); #1;
    if (O_GO) begin
      go_cnt++; run = 1; div_cnt = 0; sclk = I_CPOL;
    end
    if (O_RX_VALID) begin
      rxv_cnt++; rx_last = O_RX_DATA;
    end
    if (O_CS_N == O_BUSY) cs_err++;
    if (O_BUSY && O_TX_READY) rdy_err++;
    if (O_LAST_CLK && !last_seen) begin
      last_seen = 1; last_rise = edge_n;
    end
    pos = 1'b0; neg = 1'b0;
    if (!I_EN || !I_RST_N) begin
      run = 0;
    end else if (run) begin
      div_cnt++;
      if (div_cnt == DIV) begin
        div_cnt = 0;
        is_lead = (sclk == I_CPOL);
        if (sclk) neg = 1'b1; else pos = 1'b1;
        sclk = ~sclk;
        edge_n++;
        // Slave samples MOSI and presents MISO on the DUT's sampling edge
        if (is_lead != I_CPHA) begin
          b = I_LSB_FIRST ? (mosi_n % 8) : 7 - (mosi_n % 8);
          mosi_word[b] = O_MOSI;
          miso_drv     = cur_slv[b];
          mosi_n++;
        end
        if (O_LAST_CLK) run = 0;
      end
    end
    I_POS_EDGE = pos;
    I_NEG_EDGE = neg;
    assert (!(I_POS_EDGE && I_NEG_EDGE))
      else begin n_err++; $display("FAIL lead_trail_overlap: got 1 expected 0"); end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && !O_TX_READY; i++) step();
    chk({tag, "_ready"}, 32'(O_TX_READY), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_ready"}, 32'(O_TX_READY), 32'd0);
    chk({tag, "_rx_data"},  32'(O_RX_DATA),  32'd0);
    chk({tag, "_rx_valid"}, 32'(O_RX_VALID), 32'd0);
    chk({tag, "_go"},       32'(O_GO),       32'd0);
    chk({tag, "_last_clk"}, 32'(O_LAST_CLK), 32'd0);
    chk({tag, "_mosi"},     32'(O_MOSI),     32'd0);
    chk({tag, "_cs_n"},     32'(O_CS_N),     32'd1);
    chk({tag, "_busy"},     32'(O_BUSY),     32'd0);
  endtask

  task automatic set_mode(input logic [1:0] mode, input logic lsb, input logic loop, input logic [7:0] slv);
    I_CPOL = mode[1]; I_CPHA = mode[0]; I_LSB_FIRST = lsb;
    loop_en = loop; cur_slv = slv; miso_drv = 1'b0;
  endtask

  // Present a word and step until the GO pulse shows it was accepted
  task automatic launch(input logic [7:0] tx, input string tag);
    clr_mon();
    I_TX_DATA = tx; I_TX_VALID = 1'b1;
    for (int i = 0; i < 20 && go_cnt == 0; i++) step();
    I_TX_VALID = 1'b0;
    chk({tag, "_go_seen"}, 32'(go_cnt), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    set_mode(v.mode, v.lsb, v.loop, v.slv);
    wait_ready(tag);
    launch(v.tx, tag);
    for (int i = 0; i < 200 && rxv_cnt == 0; i++) step();
    step(); step();
    chk({tag, "_rx"},       32'(rx_last),   32'(v.exp_rx));
    chk({tag, "_rxv_cnt"},  32'(rxv_cnt),   32'd1);
    chk({tag, "_go_cnt"},   32'(go_cnt),    32'd1);
    chk({tag, "_edges"},    32'(edge_n),    32'd16);
    chk({tag, "_mosi_n"},   32'(mosi_n),    32'd8);
    chk({tag, "_mosi"},     32'(mosi_word), 32'(v.exp_mosi));
    chk({tag, "_last_at"},  32'(last_rise), 32'd15);
    chk({tag, "_cs_err"},   32'(cs_err),    32'd0);
    chk({tag, "_rdy_err"},  32'(rdy_err),   32'd0);
    chk({tag, "_cs_idle"},  32'(O_CS_N),    32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{SPI_MODE0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{SPI_MODE3, 1'b1, 1'b0, 8'h3C, 8'h81, 8'h81, 8'h3C};
    vecs[2] = '{SPI_MODE1, 1'b0, 1'b0, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[3] = '{SPI_MODE2, 1'b1, 1'b0, 8'h01, 8'h80, 8'h80, 8'h01};
    vecs[4] = '{SPI_MODE0, 1'b1, 1'b0, 8'hF0, 8'h0F, 8'h0F, 8'hF0};
    vecs[5] = '{SPI_MODE3, 1'b0, 1'b1, 8'h96, 8'h00, 8'h96, 8'h96};

    I_RST_N = 1'b0; I_EN = 1'b0; I_TX_DATA = '0; I_TX_VALID = 1'b0;
    I_POS_EDGE = 1'b0; I_NEG_EDGE = 1'b0; run = 0; div_cnt = 0; sclk = 1'b0;
    rx_last = '0; rxw[0] = '0; rxw[1] = '0;
    set_mode(SPI_MODE0, 1'b0, 1'b0, 8'h00);
    clr_mon();
    repeat (3) @(posedge clk);
    #1 check_reset("por");

    // Ready follows enable one clock later
    I_EN = 1'b1;
    #2 I_RST_N = 1'b1;
    step();
    chk("en_ready", 32'(O_TX_READY), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back: valid held high across two characters
    set_mode(SPI_MODE0, 1'b0, 1'b1, 8'h00);
    wait_ready("b2b");
    clr_mon();
    I_TX_DATA = 8'h11; I_TX_VALID = 1'b1;
    for (int i = 0; i < 400 && rxv_cnt < 2; i++) begin
      step();
      if (go_cnt == 1) I_TX_DATA = 8'h22;
      if (go_cnt >= 2) I_TX_VALID = 1'b0;
      if (O_RX_VALID && rxv_cnt >= 1 && rxv_cnt <= 2) rxw[rxv_cnt-1] = O_RX_DATA;
      if (rxv_cnt == 1 && go_cnt == 1 && O_CS_N) gap++;
    end
    I_TX_VALID = 1'b0;
    step(); step();
    chk("b2b_rxv_cnt", 32'(rxv_cnt), 32'd2);
    chk("b2b_go_cnt",  32'(go_cnt),  32'd2);
    chk("b2b_rx0",     32'(rxw[0]),  32'h11);
    chk("b2b_rx1",     32'(rxw[1]),  32'h22);
    chk("b2b_cs_gap",  32'(gap >= 1), 32'd1);
    chk("b2b_rdy_err", 32'(rdy_err), 32'd0);
    chk("b2b_cs_err",  32'(cs_err),  32'd0);
    chk("b2b_edges",   32'(edge_n),  32'd32);

    // Busy guard: a second word offered mid-transfer is ignored
    set_mode(SPI_MODE1, 1'b0, 1'b1, 8'h00);
    wait_ready("guard");
    launch(8'h5A, "guard");
    repeat (4) step();
    I_TX_DATA = 8'h77; I_TX_VALID = 1'b1;
    repeat (3) step();
    I_TX_VALID = 1'b0;
    chk("guard_busy_mid", 32'(O_BUSY), 32'd1);
    for (int i = 0; i < 200 && rxv_cnt == 0; i++) step();
    repeat (8) step();
    chk("guard_go_cnt",  32'(go_cnt),    32'd1);
    chk("guard_rxv_cnt", 32'(rxv_cnt),   32'd1);
    chk("guard_rx",      32'(rx_last),   32'h5A);
    chk("guard_mosi",    32'(mosi_word), 32'h5A);
    chk("guard_idle",    32'(O_BUSY),    32'd0);

    // Abort: enable dropped once five edge flags have been consumed
    set_mode(SPI_MODE0, 1'b0, 1'b1, 8'h00);
    wait_ready("abort");
    launch(8'hC3, "abort");
    for (int i = 0; i < 50 && edge_n < 5; i++) step();
    step();
    chk("abort_edges", 32'(edge_n), 32'd5);
    I_EN = 1'b0;
    step();
    chk("abort_cs_n",     32'(O_CS_N),     32'd1);
    chk("abort_busy",     32'(O_BUSY),     32'd0);
    chk("abort_last_clk", 32'(O_LAST_CLK), 32'd0);
    chk("abort_go",       32'(O_GO),       32'd0);
    chk("abort_rx_valid", 32'(O_RX_VALID), 32'd0);
    chk("abort_ready",    32'(O_TX_READY), 32'd0);
    chk("abort_rx_data",  32'(O_RX_DATA),  32'h5A);
    repeat (20) step();
    chk("abort_rxv_cnt",  32'(rxv_cnt), 32'd0);
    chk("abort_go_cnt",   32'(go_cnt),  32'd1);
    I_EN = 1'b1;
    wait_ready("abort_reen");

    // Asynchronous reset in the middle of a character
    launch(8'hA5, "mrst");
    for (int i = 0; i < 50 && edge_n < 6; i++) step();
    chk("mrst_busy_before", 32'(O_BUSY), 32'd1);
    #3 I_RST_N = 1'b0;
    #1 check_reset("mrst");
    step(); step();
    I_RST_N = 1'b1;
    step();
    chk("mrst_ready", 32'(O_TX_READY), 32'd1);
    run_vec('{SPI_MODE0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
